// File: rtl/aes_dec_key_sched.sv
// ============================================================================
//  Module   : aes_dec_key_sched (plus helper aes_sbox)
//  Purpose  : Iterative AES-128 decryption key scheduler. Loads a cipher key,
//             expands it forward to the round-10 key (one round per cycle),
//             then streams round keys 10..0 by running the inverse key
//             expansion step once per accepted output beat.
//  Ports    : clk, rst (async, active-high)
//             start, key_in[127:0], in_ready   - key load handshake
//             abort                            - sync abort + zeroize
//             out_valid, out_ready             - output beat handshake
//             round_key[127:0], round_num[3:0] - current round key / index
//             done                             - pulse after round-0 beat
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// AES S-box computed arithmetically: GF(2^8) inverse (x^254) then affine map.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, x254;

  // Addition chain for x^254 (= x^-1, and 0 -> 0).
  assign x2   = gf_mul(in_byte, in_byte);
  assign x3   = gf_mul(x2, in_byte);
  assign x6   = gf_mul(x3, x3);
  assign x12  = gf_mul(x6, x6);
  assign x15  = gf_mul(x12, x3);
  assign x30  = gf_mul(x15, x15);
  assign x60  = gf_mul(x30, x30);
  assign x120 = gf_mul(x60, x60);
  assign x240 = gf_mul(x120, x120);
  assign x252 = gf_mul(x240, x12);
  assign x254 = gf_mul(x252, x2);

  assign out_byte = x254 ^ {x254[6:0], x254[7]} ^ {x254[5:0], x254[7:6]}
                  ^ {x254[4:0], x254[7:5]} ^ {x254[3:0], x254[7:4]} ^ 8'h63;
endmodule

module aes_dec_key_sched #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         in_ready,
  input  logic         abort,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] round_key,
  output logic [3:0]   round_num,
  output logic         done
);
  localparam logic [3:0] C_LAST_EXPAND = 4'(NR - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    EMIT   = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   ctr_q, ctr_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic         done_q, done_d;

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [31:0] w0, w1, w2, w3;
  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  // Forward one-round expansion (used while walking up to round 10).
  logic [31:0]  fwd_sub_in, fwd_sub_out, fw0, fw1, fw2, fw3;
  logic [127:0] fwd_key;
  assign fwd_sub_in = {w3[23:0], w3[31:24]};
  for (genvar g = 0; g < 4; g++) begin : g_fwd_sbox
    aes_sbox u_sbox (.in_byte(fwd_sub_in[8*g +: 8]), .out_byte(fwd_sub_out[8*g +: 8]));
  end
  assign fw0     = w0 ^ fwd_sub_out ^ {rcon(ctr_q + 4'd1), 24'h0};
  assign fw1     = w1 ^ fw0;
  assign fw2     = w2 ^ fw1;
  assign fw3     = w3 ^ fw2;
  assign fwd_key = {fw0, fw1, fw2, fw3};

  // Inverse step: recover the previous round's w3 first, since the
  // previous w0 depends on SubWord(RotWord(prev w3)).
  logic [31:0]  p0, p1, p2, p3, inv_sub_in, inv_sub_out;
  logic [127:0] inv_key;
  assign p3         = w3 ^ w2;
  assign p2         = w2 ^ w1;
  assign p1         = w1 ^ w0;
  assign inv_sub_in = {p3[23:0], p3[31:24]};
  for (genvar g = 0; g < 4; g++) begin : g_inv_sbox
    aes_sbox u_sbox (.in_byte(inv_sub_in[8*g +: 8]), .out_byte(inv_sub_out[8*g +: 8]));
  end
  assign p0      = w0 ^ inv_sub_out ^ {rcon(ctr_q), 24'h0};
  assign inv_key = {p0, p1, p2, p3};

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    ctr_d       = ctr_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    if (abort) begin
      state_d     = IDLE;
      key_d       = '0;
      ctr_d       = 4'd0;
      out_valid_d = 1'b0;
      in_ready_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          // in_ready_q is low during the done cycle, so a start there waits.
          if (start && in_ready_q) begin
            key_d      = key_in;
            ctr_d      = 4'd0;
            state_d    = EXPAND;
            in_ready_d = 1'b0;
          end
        end
        EXPAND: begin
          key_d = fwd_key;
          ctr_d = ctr_q + 4'd1;
          if (ctr_q == C_LAST_EXPAND) begin
            state_d     = EMIT;
            out_valid_d = 1'b1;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (ctr_q != 4'd0) begin
              key_d = inv_key;
              ctr_d = ctr_q - 4'd1;
            end else begin
              state_d     = IDLE;
              key_d       = '0;
              done_d      = 1'b1;
              out_valid_d = 1'b0;
              in_ready_d  = 1'b0;
            end
          end
        end
        default: begin
          state_d     = IDLE;
          key_d       = '0;
          ctr_d       = 4'd0;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      key_q       <= '0;
      ctr_q       <= 4'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      ctr_q       <= ctr_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  // Key material never leaves the block unless a beat is being presented.
  assign round_key = out_valid_q ? key_q : '0;
  assign round_num = out_valid_q ? ctr_q : 4'd0;
endmodule

`default_nettype wire

// File: tb/tb_aes_dec_key_sched.sv
// ============================================================================
//  Module   : tb_aes_dec_key_sched
//  Purpose  : Self-checking bench for aes_dec_key_sched. Expected round keys
//             come from a textbook FIPS-197 word-by-word key expansion using
//             an S-box table generated at time zero.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_dec_key_sched;
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         in_ready;
  logic         abort;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] round_key;
  logic [3:0]   round_num;
  logic         done;

  aes_dec_key_sched dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .in_ready(in_ready),
    .abort(abort), .out_valid(out_valid), .out_ready(out_ready),
    .round_key(round_key), .round_num(round_num), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   sbox_t [0:255];
  logic [127:0] exp_rk [0:10];
  logic [127:0] got_rk [0:10];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  // Classic generator walk: p runs over GF(2^8)* by multiplying by 3,
  // q tracks p^-1 by dividing by 3.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int i = 0; i < 255; i++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end
    sbox_t[0] = 8'h63;
  endtask

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Called right after the edge on which the key was accepted. Returns at
  // the observation where done should be high; lat = cycles since acceptance.
  task automatic collect(input logic [127:0] k, input bit stall, input bit keep_start, output int lat);
    int cyc;
    int r;
    int guard;
    model_expand(k);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      check_val("expand_key_hidden", round_key, 128'h0);
      check_val("expand_busy", {127'h0, in_ready}, 128'h0);
      check_val("expand_no_done", {127'h0, done}, 128'h0);
      if (keep_start) key_in = {$urandom, $urandom, $urandom, $urandom};
      tick();
      cyc++;
    end
    check_val("first_beat_latency", 128'(cyc), 128'd10);
    r = 10;
    guard = 0;
    while (r >= 0 && guard < 400) begin
      check_val("beat_valid", {127'h0, out_valid}, 128'h1);
      check_val("beat_num", {124'h0, round_num}, 128'(r));
      check_val("beat_key", round_key, exp_rk[r]);
      check_val("beat_no_done", {127'h0, done}, 128'h0);
      check_val("beat_busy", {127'h0, in_ready}, 128'h0);
      out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (out_ready) got_rk[r] = round_key;
      if (keep_start) key_in = {$urandom, $urandom, $urandom, $urandom};
      tick();
      cyc++;
      guard++;
      if (out_ready) r--;
    end
    check_val("beats_finished", {127'h0, (r < 0)}, 128'h1);
    check_val("done_pulse", {127'h0, done}, 128'h1);
    check_val("done_valid_low", {127'h0, out_valid}, 128'h0);
    check_val("done_key_zero", round_key, 128'h0);
    check_val("done_busy", {127'h0, in_ready}, 128'h0);
    lat = cyc;
  endtask

  task automatic after_done();
    tick();
    check_val("done_one_cycle", {127'h0, done}, 128'h0);
    check_val("idle_ready", {127'h0, in_ready}, 128'h1);
  endtask

  task automatic launch(input logic [127:0] k);
    key_in = k;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  initial begin
    int lat;
    int n;
    logic [127:0] k;
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0; key_in = '0;
    build_sbox();
    tick();
    tick();
    check_val("rst_in_ready", {127'h0, in_ready}, 128'h1);
    check_val("rst_out_valid", {127'h0, out_valid}, 128'h0);
    check_val("rst_round_key", round_key, 128'h0);
    check_val("rst_round_num", {124'h0, round_num}, 128'h0);
    check_val("rst_done", {127'h0, done}, 128'h0);
    rst = 1'b0;
    tick();

    // FIPS-197 vector, no back-pressure.
    launch(FIPS_KEY);
    collect(FIPS_KEY, 1'b0, 1'b0, lat);
    check_val("fips_total_latency", 128'(lat), 128'd21);
    check_val("fips_round10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check_val("fips_round1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check_val("fips_round0", got_rk[0], FIPS_KEY);
    after_done();

    // Same key with random stalls.
    launch(FIPS_KEY);
    collect(FIPS_KEY, 1'b1, 1'b0, lat);
    after_done();

    // Abort while round 5 is presented.
    out_ready = 1'b1;
    launch(FIPS_KEY);
    n = 0;
    while (!(out_valid && round_num == 4'd5) && n < 40) begin
      tick();
      n++;
    end
    check_val("abort_reached_r5", {124'h0, round_num}, 128'd5);
    abort = 1'b1;
    key_in = SEQ_KEY;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check_val("abort_valid_low", {127'h0, out_valid}, 128'h0);
    check_val("abort_in_ready", {127'h0, in_ready}, 128'h1);
    check_val("abort_key_zero", round_key, 128'h0);
    check_val("abort_no_done", {127'h0, done}, 128'h0);
    tick();
    check_val("abort_no_done_later", {127'h0, done}, 128'h0);
    check_val("abort_still_idle", {127'h0, out_valid}, 128'h0);
    k = {$urandom, $urandom, $urandom, $urandom};
    launch(k);
    collect(k, 1'b1, 1'b0, lat);
    after_done();

    // Asynchronous reset in the middle of expansion (ctr = 4).
    launch({$urandom, $urandom, $urandom, $urandom});
    repeat (4) tick();
    check_val("mid_expand_busy", {127'h0, in_ready}, 128'h0);
    #2 rst = 1'b1;
    #1;
    check_val("arst_in_ready", {127'h0, in_ready}, 128'h1);
    check_val("arst_out_valid", {127'h0, out_valid}, 128'h0);
    check_val("arst_round_key", round_key, 128'h0);
    check_val("arst_round_num", {124'h0, round_num}, 128'h0);
    check_val("arst_done", {127'h0, done}, 128'h0);
    rst = 1'b0;
    tick();
    check_val("post_rst_idle", {127'h0, in_ready}, 128'h1);
    check_val("post_rst_valid", {127'h0, out_valid}, 128'h0);

    // start held high through a whole run, then a new key right at done.
    k = {$urandom, $urandom, $urandom, $urandom};
    key_in = k;
    start = 1'b1;
    tick();
    collect(k, 1'b1, 1'b1, lat);
    key_in = SEQ_KEY;
    tick();
    check_val("start_at_done_ignored", {127'h0, in_ready}, 128'h1);
    check_val("start_at_done_no_valid", {127'h0, out_valid}, 128'h0);
    check_val("start_at_done_no_done", {127'h0, done}, 128'h0);
    tick();
    start = 1'b0;
    check_val("start_next_accepted", {127'h0, in_ready}, 128'h0);
    collect(SEQ_KEY, 1'b0, 1'b0, lat);
    check_val("seq_total_latency", 128'(lat), 128'd21);
    check_val("seq_round10", got_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    check_val("seq_round0", got_rk[0], SEQ_KEY);
    after_done();

    // A few more random keys with random back-pressure.
    for (int i = 0; i < 4; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      launch(k);
      collect(k, 1'b1, 1'b0, lat);
      after_done();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/aes_dec_key_sched.md
Name: aes_dec_key_sched

Overview:
Iterative AES-128 decryption key scheduler for the serial-link security wrapper.
- Accepts the cipher key and expands it forward 10 rounds, one round per cycle, reusing the forward one-round expander.
- Then emits round keys in reverse order (10 down to 0) by running the inverse key-expansion step once per accepted output beat.
- Feeds the AES decrypt datapath, which consumes round keys last-to-first.

Parameters:
- NR, 10, number of AES rounds; fixed for AES-128, not to be overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request to load key_in; accepted when start & in_ready.
- key_in  in  128  cipher key (round-0 key), word 0 in [127:96].
- in_ready  out  1  high only in IDLE.
- abort  in  1  synchronous abort and zeroize; returns to IDLE.
- out_valid  out  1  round_key and round_num are valid.
- out_ready  in  1  consumer accepts the current beat.
- round_key  out  128  current round key; 0 when out_valid is low.
- round_num  out  4  round index of round_key (10..0).
- done  out  1  one-cycle pulse after the round-0 beat is accepted.

Behaviour:
- Reset values: state IDLE, key register 0, round counter 0, in_ready=1, out_valid=0, round_key=0, round_num=0, done=0.
- FSM has three states: IDLE, EXPAND, EMIT.
- IDLE:
  - in_ready=1.
  - On start: key_reg<=key_in, ctr<=0, go to EXPAND.
  - start while not in IDLE is ignored.
- EXPAND:
  - Each cycle: key_reg<=fwd(key_reg, RCON[ctr+1]), then ctr<=ctr+1.
  - When ctr reaches 10, go to EMIT.
  - out_valid rises 10 cycles after the start-acceptance edge (10 expansion edges).
  - out_valid=0 and in_ready=0 throughout.
- RCON[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- fwd() is the standard AES-128 one-round key expansion: w0'=w0^SubWord(RotWord(w3))^{rcon,24'h0}, then w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
- EMIT:
  - out_valid=1, round_key=key_reg, round_num=ctr.
  - Hold all outputs stable while out_ready=0.
  - On out_valid & out_ready with ctr>0: key_reg<=inv(key_reg, RCON[ctr]), ctr<=ctr-1. The next beat is valid the following cycle, so zero-bubble streaming is possible.
  - On accept with ctr==0: go to IDLE, key_reg<=0, done=1 for exactly one cycle, out_valid=0.
- inv() is the inverse step:
  - p3=w3^w2, p2=w2^w1, p1=w1^w0.
  - p0=w0^SubWord(RotWord(p3))^{rcon,24'h0}.
  - Uses 4 aes_sbox instances dedicated to the inverse path.
- abort:
  - Takes priority over every other transition in any state.
  - Next state IDLE; key_reg and ctr cleared; out_valid=0.
  - done is not pulsed.
  - start in the same cycle as abort is ignored.
- Asynchronous rst mid-operation: immediate return to the reset values; no partial key remains visible on any output.
- The secret is zeroized on every exit to IDLE (done, abort, rst).
- round_key is forced to 0 whenever out_valid=0.
- Each key consumes exactly 11 output beats; a new start is accepted only after done.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, out_ready=1 → first beat after 10 cycles: round_num=10, round_key=d014f9a8c9ee2589e13f0cc8b6630ca6. Then 11 consecutive beats; round_num=1 gives a0fafe1788542cb123a339392a6c7605; round_num=0 gives the original key. done pulses once; total latency is 21 cycles from start.
- Same key, out_ready toggled randomly → identical key sequence. round_key and round_num stay stable during every stall, and no beat is dropped or duplicated.
- Assert abort while round_num=5 is presented → next cycle out_valid=0, in_ready=1, round_key=0, no done pulse. A fresh start then produces the full correct sequence.
- Assert rst asynchronously mid-EXPAND (ctr=4) → all outputs return to reset values immediately. After release, the FSM is in IDLE.
- start held high continuously through a run → only the first assertion is accepted. After done, the next start loads a new key (000102030405060708090a0b0c0d0e0f), and round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
- start asserted in the same cycle as done → start is ignored (in_ready=0); it is accepted on the following cycle.
